poly1305_key_loader: RTL and testbench

//  Collects the 256-bit Poly1305 one-time key as eight 32-bit little-endian words from the

---
 rtl/poly1305_key_loader_if.sv | 22 ++
 rtl/poly1305_key_loader.sv | 89 ++++++++
 tb/tb_poly1305_key_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/poly1305_key_loader_if.sv
// rtl/poly1305_key_loader_if.sv - key word stream, key hand-off and status signals of the Poly1305 key loader
interface poly1305_key_loader_if;
  logic         start;
  logic         key_word_valid;
  logic [31:0]  key_word;
  logic         key_word_ready;
  logic         key_valid;
  logic         key_consume;
  logic [127:0] unclamped_r;
  logic [127:0] s;
  logic         busy;

  modport master (
    output start, key_word_valid, key_word, key_consume,
    input  key_word_ready, key_valid, unclamped_r, s, busy
  );

  modport slave (
    input  start, key_word_valid, key_word, key_consume,
    output key_word_ready, key_valid, unclamped_r, s, busy
  );
endinterface

// File: rtl/poly1305_key_loader.sv
// rtl/poly1305_key_loader.sv - gathers the 256-bit one-time key into raw r and s halves and holds it until acknowledged
module poly1305_key_loader (
  input  logic                  clock,
  input  logic                  clear_n,
  poly1305_key_loader_if.slave  bus
);

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;

  typedef enum logic [1:0] {IDLE, LOAD_R, LOAD_S, HOLD} state_t;

  state_t                                state_q, state_d;
  logic [1:0]                            cnt_q, cnt_d;
  logic [NUM_WORDS/2-1:0][WORD_W-1:0]    r_q, r_d;
  logic [NUM_WORDS/2-1:0][WORD_W-1:0]    s_q, s_d;
  logic                                  ready_q, ready_d;
  logic                                  key_valid_q, key_valid_d;
  logic                                  busy_q, busy_d;
  logic                                  xfer;

  // A word offered in the start cycle belongs to the abandoned key, so ready is
  // withheld for that one cycle; ready never depends on key_word_valid.
  assign bus.key_word_ready = ready_q & ~bus.start;
  assign xfer               = bus.key_word_valid & ready_q & ~bus.start;

  assign bus.key_valid   = key_valid_q;
  assign bus.busy        = busy_q;
  assign bus.unclamped_r = r_q;
  assign bus.s           = s_q;

  // Next-state, word placement and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    s_d     = s_q;
    if (bus.start) begin
      state_d = LOAD_R;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        LOAD_R: begin
          if (xfer) begin
            r_d[cnt_q] = bus.key_word;
            cnt_d      = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = LOAD_S;
          end
        end
        LOAD_S: begin
          if (xfer) begin
            s_d[cnt_q] = bus.key_word;
            cnt_d      = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.key_consume) state_d = IDLE;
        end
        default: ;
      endcase
    end
    ready_d     = (state_d == LOAD_R) || (state_d == LOAD_S);
    busy_d      = ready_d;
    key_valid_d = (state_d == HOLD);
  end

  // State, counter, key halves and status flags.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      r_q         <= '0;
      s_q         <= '0;
      ready_q     <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      s_q         <= s_d;
      ready_q     <= ready_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_poly1305_key_loader.sv
// tb/tb_poly1305_key_loader.sv - directed self-checking bench for poly1305_key_loader
module tb_poly1305_key_loader;

  logic clock = 1'b0;
  logic clear_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_cnt = 0;

  poly1305_key_loader_if bus();

  poly1305_key_loader dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Offers n words in order, optionally with random idle gaps, waiting (bounded) for ready.
  task automatic send_words(input logic [31:0] w [8], input int n, input bit gaps);
    int waited;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.key_word_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.key_word_valid = 1'b1;
      bus.key_word       = w[i];
      waited = 0;
      @(negedge clock);
      while (bus.key_word_ready !== 1'b1 && waited < 50) begin
        waited++;
        @(negedge clock);
      end
      if (waited >= 50) check("ready_timeout", 1'b0, 1'b1);
      check("kv_low_during_load", bus.key_valid, 1'b0);
      tick();
    end
    bus.key_word_valid = 1'b0;
  endtask

  logic [31:0] rfc_w [8];
  logic [31:0] seq_w [8];
  logic [31:0] old_w [8];
  logic [31:0] a_w   [8];
  logic [31:0] c_w   [8];
  logic [127:0] r_saved;
  int e0;
  bit hold_ok;

  initial begin
    rfc_w = '{32'h78bed685, 32'h336d5557, 32'hfe52447f, 32'ha806d542,
              32'h8a800301, 32'hfdb20dfb, 32'haff6bf4a, 32'h1bf54941};
    for (int i = 0; i < 8; i++) begin
      seq_w[i] = i;
      old_w[i] = 32'h55550000 + i;
      a_w[i]   = 32'hA0 + i;
      c_w[i]   = 32'hC0DE0000 + i;
    end

    bus.start          = 1'b0;
    bus.key_word_valid = 1'b0;
    bus.key_word       = '0;
    bus.key_consume    = 1'b0;

    // T1: reset
    clear_n = 1'b0;
    repeat (3) tick();
    clear_n = 1'b1;
    tick();
    @(negedge clock);
    check("rst_ready", bus.key_word_ready, 1'b0);
    check("rst_key_valid", bus.key_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_r", bus.unclamped_r, 128'h0);
    check("rst_s", bus.s, 128'h0);

    // valid and consume in IDLE are ignored
    bus.key_word_valid = 1'b1;
    bus.key_word       = 32'hFFFFFFFF;
    bus.key_consume    = 1'b1;
    repeat (3) tick();
    bus.key_word_valid = 1'b0;
    bus.key_consume    = 1'b0;
    @(negedge clock);
    check("idle_ignore_busy", bus.busy, 1'b0);
    check("idle_ignore_ready", bus.key_word_ready, 1'b0);
    check("idle_ignore_r", bus.unclamped_r, 128'h0);

    // T2: RFC 8439 key, back-to-back, latency
    tick();
    e0 = edge_cnt;
    pulse_start();
    send_words(rfc_w, 8, 1'b0);
    check("t2_latency_edges", edge_cnt - e0, 9);
    check("t2_key_valid", bus.key_valid, 1'b1);
    check("t2_r", bus.unclamped_r, 128'ha806d542_fe52447f_336d5557_78bed685);
    check("t2_s", bus.s, 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301);
    check("t2_busy", bus.busy, 1'b0);

    // T5: hold without consume, then consume, then consume+start
    hold_ok = 1'b1;
    bus.key_word_valid = 1'b1;
    bus.key_word       = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.key_valid !== 1'b1 || bus.key_word_ready !== 1'b0) hold_ok = 1'b0;
    end
    bus.key_word_valid = 1'b0;
    check("t5_hold_20", hold_ok, 1'b1);
    check("t5_hold_r", bus.unclamped_r, 128'ha806d542_fe52447f_336d5557_78bed685);
    tick();
    bus.key_consume = 1'b1;
    tick();
    bus.key_consume = 1'b0;
    check("t5_consume_kv", bus.key_valid, 1'b0);
    check("t5_consume_busy", bus.busy, 1'b0);
    check("t5_r_retained", bus.unclamped_r, 128'ha806d542_fe52447f_336d5557_78bed685);
    e0 = edge_cnt;
    pulse_start();
    send_words(rfc_w, 8, 1'b0);
    check("t5_reload_kv", bus.key_valid, 1'b1);
    bus.key_consume = 1'b1;
    bus.start       = 1'b1;
    tick();
    bus.key_consume = 1'b0;
    bus.start       = 1'b0;
    check("t5_cs_kv", bus.key_valid, 1'b0);
    check("t5_cs_busy", bus.busy, 1'b1);
    @(negedge clock);
    check("t5_cs_ready", bus.key_word_ready, 1'b1);

    // T3: words 0..7 with random valid stalls (already in LOAD_R)
    send_words(seq_w, 8, 1'b1);
    tick();
    check("t3_kv", bus.key_valid, 1'b1);
    check("t3_r", bus.unclamped_r, {32'd3, 32'd2, 32'd1, 32'd0});
    check("t3_s", bus.s, {32'd7, 32'd6, 32'd5, 32'd4});

    // T4: start from HOLD, 5 words, restart with a word offered in the start cycle
    pulse_start();
    check("t4_start_hold_kv", bus.key_valid, 1'b0);
    send_words(old_w, 5, 1'b0);
    check("t4_midload_busy", bus.busy, 1'b1);
    bus.key_word_valid = 1'b1;
    bus.key_word       = 32'hDEADBEEF;
    bus.start          = 1'b1;
    @(negedge clock);
    check("t4_start_ready_low", bus.key_word_ready, 1'b0);
    tick();
    bus.start          = 1'b0;
    bus.key_word_valid = 1'b0;
    send_words(a_w, 8, 1'b0);
    check("t4_kv", bus.key_valid, 1'b1);
    check("t4_r", bus.unclamped_r, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("t4_s", bus.s, {32'hA7, 32'hA6, 32'hA5, 32'hA4});

    // T6: async reset after 6 words, then a clean load
    pulse_start();
    send_words(c_w, 6, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    check("t6_async_busy", bus.busy, 1'b0);
    check("t6_async_ready", bus.key_word_ready, 1'b0);
    check("t6_async_r", bus.unclamped_r, 128'h0);
    check("t6_async_s", bus.s, 128'h0);
    @(negedge clock);
    clear_n = 1'b1;
    tick();
    pulse_start();
    send_words(c_w, 8, 1'b0);
    check("t6_kv", bus.key_valid, 1'b1);
    check("t6_r", bus.unclamped_r, {c_w[3], c_w[2], c_w[1], c_w[0]});
    check("t6_s", bus.s, {c_w[7], c_w[6], c_w[5], c_w[4]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
